// File: rtl/alu_issue_seq.sv
// Issue sequencer: decodes one instruction, drives the combinational ALU for a
// single cycle from flops, captures the result and presents it with a branch decision.
module alu_issue_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [15:0]      in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [1:0]       alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_is_branch,
    output logic             res_taken,
    output logic             res_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_data;
    logic [2:0]       r_ctrl;
    logic             r_zero, r_br, r_bne, r_taken, r_err;

    logic [WIDTH-1:0] w_b, w_sext, w_zext;
    logic [2:0]       w_ctrl;
    logic             w_err, w_br, w_bne, w_accept;
    logic             w_unused_zero_hi;

    assign w_unused_zero_hi = alu_zero[1];
    assign w_sext = {{(WIDTH-16){in_imm[15]}}, in_imm};
    assign w_zext = {{(WIDTH-16){1'b0}}, in_imm};

    always_comb begin
        w_ctrl = 3'b000;
        w_b    = in_rt_val;
        w_err  = 1'b0;
        w_br   = 1'b0;
        w_bne  = 1'b0;
        case (in_opcode)
            6'b000000: begin
                case (in_funct)
                    6'b100000: w_ctrl = 3'b100;
                    6'b100010: w_ctrl = 3'b110;
                    6'b100100: w_ctrl = 3'b000;
                    6'b100101: w_ctrl = 3'b001;
                    6'b100110: w_ctrl = 3'b010;
                    6'b100111: w_ctrl = 3'b111;
                    6'b101010: w_ctrl = 3'b011;
                    6'b101111: begin
                        w_ctrl = 3'b101;
                        w_b    = '0;
                    end
                    default:   w_err = 1'b1;
                endcase
            end
            6'b001000: begin w_ctrl = 3'b100; w_b = w_sext; end
            6'b001010: begin w_ctrl = 3'b011; w_b = w_sext; end
            6'b001100: begin w_ctrl = 3'b000; w_b = w_zext; end
            6'b001101: begin w_ctrl = 3'b001; w_b = w_zext; end
            6'b001110: begin w_ctrl = 3'b010; w_b = w_zext; end
            6'b000100: begin w_ctrl = 3'b110; w_br = 1'b1; end
            6'b000101: begin w_ctrl = 3'b110; w_br = 1'b1; w_bne = 1'b1; end
            default:   w_err = 1'b1;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign res_valid = (r_state == S_RESP);
    assign w_accept  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_err ? S_RESP : S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Unsupported instructions leave the ALU drive registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= 3'b000;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_br    <= 1'b0;
            r_bne   <= 1'b0;
            r_taken <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_err) begin
                r_data  <= '0;
                r_zero  <= 1'b0;
                r_br    <= 1'b0;
                r_bne   <= 1'b0;
                r_taken <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                r_a    <= in_rs_val;
                r_b    <= w_b;
                r_ctrl <= w_ctrl;
                r_br   <= w_br;
                r_bne  <= w_bne;
                r_err  <= 1'b0;
            end
        end else if (r_state == S_EXEC) begin
            r_data  <= alu_out;
            r_zero  <= alu_zero[0];
            r_taken <= r_br & (alu_zero[0] ^ r_bne);
        end
    end

    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_ctrl      = r_ctrl;
    assign res_data      = r_data;
    assign res_zero      = r_zero;
    assign res_is_branch = r_br;
    assign res_taken     = r_taken;
    assign res_err       = r_err;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: a stand-in combinational ALU plus an instruction-level
// reference model that computes results directly from instruction semantics.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, res_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [31:0] in_rs_val, in_rt_val, alu_a, alu_b, alu_out, res_data;
    logic [15:0] in_imm;
    logic [2:0]  alu_ctrl;
    logic [1:0]  alu_zero;
    logic        res_valid, res_zero, res_is_branch, res_taken, res_err;
    logic        zb1 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [2:0]  ctrl;
        logic [31:0] a, b, data;
        logic        zero, br, taken;
    } exp_t;

    typedef struct {
        int          lat;
        logic        rdy, valid;
        logic [31:0] a, b, data;
        logic [2:0]  ctrl;
        logic        zero, br, taken, err;
    } obs_t;

    logic [11:0] ops [15] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
        {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2F},
        {6'h08, 6'h00}, {6'h0A, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00},
        {6'h0E, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}
    };

    alu_issue_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_rs_val(in_rs_val),
        .in_rt_val(in_rt_val), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .res_err(res_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) zb1 <= 1'($urandom);

    always_comb begin
        alu_out = 32'h0;
        case (alu_ctrl)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: alu_out = alu_a ^ alu_b;
            3'b011: alu_out = (alu_a < alu_b) ? 32'h1 : 32'h0;
            3'b100: alu_out = alu_a + alu_b;
            3'b101: alu_out = ~alu_a;
            3'b110: alu_out = alu_a - alu_b;
            3'b111: alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'h0;
        endcase
        alu_zero = {zb1, (alu_out == 32'h0)};
    end

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] f,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm);
        exp_t e;
        logic [31:0] sx, zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        e = '{err: 1'b0, ctrl: 3'b000, a: rs, b: rt, data: 32'h0, zero: 1'b0, br: 1'b0, taken: 1'b0};
        if (op == 6'h00) begin
            case (f)
                6'h20: begin e.ctrl = 3'b100; e.data = rs + rt; end
                6'h22: begin e.ctrl = 3'b110; e.data = rs - rt; end
                6'h24: begin e.ctrl = 3'b000; e.data = rs & rt; end
                6'h25: begin e.ctrl = 3'b001; e.data = rs | rt; end
                6'h26: begin e.ctrl = 3'b010; e.data = rs ^ rt; end
                6'h27: begin e.ctrl = 3'b111; e.data = ~(rs | rt); end
                6'h2A: begin e.ctrl = 3'b011; e.data = (rs < rt) ? 32'h1 : 32'h0; end
                6'h2F: begin e.ctrl = 3'b101; e.b = 32'h0; e.data = ~rs; end
                default: e.err = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08: begin e.ctrl = 3'b100; e.b = sx; e.data = rs + sx; end
                6'h0A: begin e.ctrl = 3'b011; e.b = sx; e.data = (rs < sx) ? 32'h1 : 32'h0; end
                6'h0C: begin e.ctrl = 3'b000; e.b = zx; e.data = rs & zx; end
                6'h0D: begin e.ctrl = 3'b001; e.b = zx; e.data = rs | zx; end
                6'h0E: begin e.ctrl = 3'b010; e.b = zx; e.data = rs ^ zx; end
                6'h04: begin e.ctrl = 3'b110; e.data = rs - rt; e.br = 1'b1; e.taken = (rs == rt); end
                6'h05: begin e.ctrl = 3'b110; e.data = rs - rt; e.br = 1'b1; e.taken = (rs != rt); end
                default: e.err = 1'b1;
            endcase
        end
        e.zero = !e.err && (e.data == 32'h0);
        return e;
    endfunction

    task automatic run_op(input logic [5:0] op, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm, output obs_t o);
        @(negedge clk);
        in_opcode = op; in_funct = f; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
        in_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_opcode = 6'($urandom); in_funct = 6'($urandom);
        in_rs_val = $urandom; in_rt_val = $urandom; in_imm = 16'($urandom);
        @(negedge clk);
        o.lat = 1; o.rdy = in_ready; o.a = alu_a; o.b = alu_b; o.ctrl = alu_ctrl;
        while (!res_valid && o.lat < 8) begin
            @(negedge clk);
            o.lat++;
        end
        o.valid = res_valid; o.data = res_data; o.zero = res_zero;
        o.br = res_is_branch; o.taken = res_taken; o.err = res_err;
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_opcode = '0; in_funct = '0; in_rs_val = '0; in_rt_val = '0; in_imm = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 67'h0) begin errors++; $display("FAIL rst_alu_bus: got %h/%h/%b expected 0", alu_a, alu_b, alu_ctrl); end
        checks++; if ({res_data, res_zero, res_is_branch, res_taken, res_err} !== 36'h0) begin errors++; $display("FAIL rst_res: got %h expected 0", {res_data, res_zero, res_is_branch, res_taken, res_err}); end
        @(negedge clk) rst_n = 1'b1;
        // Reset again while an add is in EXEC.
        @(negedge clk);
        in_opcode = 6'h00; in_funct = 6'h20; in_rs_val = 32'd5; in_rt_val = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 67'h0) begin errors++; $display("FAIL midexec_rst_alu: got %h/%h/%b expected 0", alu_a, alu_b, alu_ctrl); end
        checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL midexec_rst_state: got rdy=%b vld=%b expected 1/0", in_ready, res_valid); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midexec_no_result: got vld=%b rdy=%b expected 0/1", res_valid, in_ready); end
    endtask

    task automatic test_add();
        obs_t o;
        run_op(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, o);
        checks++; if (o.ctrl !== 3'b100) begin errors++; $display("FAIL add_ctrl: got %b expected 100", o.ctrl); end
        checks++; if (o.rdy !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b expected 0", o.rdy); end
        checks++; if (o.lat !== 2 || o.valid !== 1'b1) begin errors++; $display("FAIL add_latency: got %0d expected 2", o.lat); end
        checks++; if (o.data !== 32'd12 || o.zero !== 1'b0 || o.err !== 1'b0) begin errors++; $display("FAIL add_result: got %h z=%b e=%b expected 0000000c z=0 e=0", o.data, o.zero, o.err); end
        release_res();
    endtask

    task automatic test_imm();
        obs_t o;
        run_op(6'h08, 6'h00, 32'd10, 32'h0, 16'hFFFF, o);
        checks++; if (o.b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_sext: got %h expected ffffffff", o.b); end
        checks++; if (o.data !== 32'd9) begin errors++; $display("FAIL addi_data: got %h expected 00000009", o.data); end
        release_res();
        run_op(6'h0C, 6'h00, 32'hFFFF0F0F, 32'h0, 16'hFFFF, o);
        checks++; if (o.b !== 32'h0000FFFF) begin errors++; $display("FAIL andi_zext: got %h expected 0000ffff", o.b); end
        checks++; if (o.data !== 32'h00000F0F) begin errors++; $display("FAIL andi_data: got %h expected 00000f0f", o.data); end
        release_res();
    endtask

    task automatic test_branch();
        obs_t o;
        run_op(6'h04, 6'h00, 32'd3, 32'd3, 16'h0, o);
        checks++; if (o.ctrl !== 3'b110) begin errors++; $display("FAIL beq_ctrl: got %b expected 110", o.ctrl); end
        checks++; if ({o.data, o.zero, o.br, o.taken} !== {32'h0, 3'b111}) begin errors++; $display("FAIL beq_taken: got %h z=%b br=%b tk=%b expected 0 1 1 1", o.data, o.zero, o.br, o.taken); end
        release_res();
        run_op(6'h05, 6'h00, 32'd3, 32'd3, 16'h0, o);
        checks++; if (o.taken !== 1'b0 || o.br !== 1'b1) begin errors++; $display("FAIL bne_equal: got br=%b tk=%b expected 1 0", o.br, o.taken); end
        release_res();
        run_op(6'h05, 6'h00, 32'd4, 32'd3, 16'h0, o);
        checks++; if (o.taken !== 1'b1 || o.zero !== 1'b0) begin errors++; $display("FAIL bne_differ: got z=%b tk=%b expected 0 1", o.zero, o.taken); end
        release_res();
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_op(6'h00, 6'h25, 32'h0000F000, 32'h0000000F, 16'h0, o);
        for (int c = 0; c < 5; c++) begin
            in_opcode = 6'h00; in_funct = 6'h20; in_rs_val = $urandom; in_valid = (c % 2 == 0);
            @(negedge clk);
            checks++; if (res_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_state: got vld=%b rdy=%b expected 1/0", res_valid, in_ready); end
            checks++; if (res_data !== 32'h0000F00F || res_err !== 1'b0) begin errors++; $display("FAIL bp_hold_data: got %h expected 0000f00f", res_data); end
        end
        in_valid = 1'b0;
        release_res();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1/0", in_ready, res_valid); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored_pulse: got rdy=%b expected 1", in_ready); end
    endtask

    task automatic test_error();
        obs_t o;
        run_op(6'h00, 6'h26, 32'h12345678, 32'h0F0F0F0F, 16'h0, o);
        release_res();
        run_op(6'h3F, 6'h20, 32'd1, 32'd2, 16'h1, o);
        checks++; if (o.lat !== 1 || o.valid !== 1'b1) begin errors++; $display("FAIL err_latency: got %0d expected 1", o.lat); end
        checks++; if (o.err !== 1'b1 || o.data !== 32'h0 || o.br !== 1'b0 || o.taken !== 1'b0 || o.zero !== 1'b0) begin errors++; $display("FAIL err_result: got e=%b d=%h expected 1 0", o.err, o.data); end
        checks++; if (o.ctrl !== 3'b010) begin errors++; $display("FAIL err_ctrl_kept: got %b expected 010", o.ctrl); end
        release_res();
        run_op(6'h00, 6'h01, 32'd1, 32'd2, 16'h1, o);
        checks++; if (o.err !== 1'b1 || o.lat !== 1) begin errors++; $display("FAIL err_funct: got e=%b lat=%0d expected 1 1", o.err, o.lat); end
        release_res();
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [5:0] op, f;
        logic [31:0] rs, rt;
        logic [15:0] imm;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 17);
            rs = $urandom; rt = ($urandom_range(0, 2) == 0) ? rs : $urandom; imm = 16'($urandom);
            if (k < 15) begin
                op = ops[k][11:6]; f = (op == 6'h00) ? ops[k][5:0] : 6'($urandom);
            end else if (k == 15) begin
                op = 6'h00; f = 6'h3E;
            end else begin
                op = (k == 16) ? 6'h02 : 6'h23; f = 6'h20;
            end
            e = model(op, f, rs, rt, imm);
            run_op(op, f, rs, rt, imm, o);
            checks++; if (o.lat !== (e.err ? 1 : 2)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, o.lat, e.err ? 1 : 2); end
            checks++; if ({o.err, o.data, o.zero, o.br, o.taken} !== {e.err, e.data, e.zero, e.br, e.taken}) begin errors++; $display("FAIL rnd_result[%0d] op=%h f=%h: got e=%b d=%h z=%b br=%b tk=%b expected e=%b d=%h z=%b br=%b tk=%b", i, op, f, o.err, o.data, o.zero, o.br, o.taken, e.err, e.data, e.zero, e.br, e.taken); end
            if (!e.err) begin
                checks++; if ({o.ctrl, o.a, o.b} !== {e.ctrl, e.a, e.b}) begin errors++; $display("FAIL rnd_alu_drive[%0d]: got %b %h %h expected %b %h %h", i, o.ctrl, o.a, o.b, e.ctrl, e.a, e.b); end
            end
            release_res();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [5:0] op, f;
        logic [31:0] rs, rt;
        int n, t_now, t_prev;
        t_prev = 0;
        res_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            op = ops[i][11:6]; f = ops[i][5:0];
            rs = $urandom; rt = (i % 2 == 1) ? rs : $urandom;
            in_opcode = op; in_funct = f; in_rs_val = rs; in_rt_val = rt; in_imm = 16'($urandom);
            e = model(op, f, rs, rt, in_imm);
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            t_now = cyc;
            in_valid = 1'b0;
            if (i > 0) begin
                checks++; if (t_now - t_prev !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, t_now - t_prev); end
            end
            t_prev = t_now;
            @(negedge clk);
            n = 0;
            while (!res_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++; if ({res_valid, res_err, res_data, res_zero, res_is_branch, res_taken} !== {1'b1, 1'b0, e.data, e.zero, e.br, e.taken}) begin errors++; $display("FAIL b2b_result[%0d]: got v=%b e=%b d=%h z=%b br=%b tk=%b expected v=1 e=0 d=%h z=%b br=%b tk=%b", i, res_valid, res_err, res_data, res_zero, res_is_branch, res_taken, e.data, e.zero, e.br, e.taken); end
        end
        res_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_branch();
        test_backpressure();
        test_error();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
